// File: rtl/ds_serial_pkg.sv
// Shared types and constants for the ds_serial receive/transmit family.
package ds_serial_pkg;

   // Receiver FSM states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } rx_state_t;

   // Level of the serial line when nothing is being sent
   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/ds_sync_bit.sv
// Multi-flop synchronizer for one asynchronous bit; resets to the idle line level.
module ds_sync_bit
   import ds_serial_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_r;

   // Shift the asynchronous input through the flop chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {STAGES{LINE_IDLE}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
      end
   end

   assign q = sync_r[STAGES-1];

endmodule

// File: rtl/ds_serial_rx.sv
// Oversampling serial receiver: start detect, mid-bit sampling, LSB-first
// data, stop check, and a one-entry valid/ready holding register.
module ds_serial_rx
   import ds_serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun
);

   localparam int BIT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_MID  = BIT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   logic              ds_s;
   logic              ds_prev_r;
   rx_state_t         state_r, state_nxt_s;
   logic [BIT_W-1:0]  bitcnt_r, bitcnt_nxt_s;
   logic [IDX_W-1:0]  idx_r, idx_nxt_s;
   logic [DATA_W-1:0] shift_r, shift_nxt_s;
   logic              deliver_s;
   logic              frame_err_nxt_s;
   logic              take_s;
   logic [DATA_W-1:0] out_data_r, out_data_nxt_s;
   logic              out_valid_r, out_valid_nxt_s;
   logic              overrun_r, overrun_nxt_s;
   logic              frame_err_r;
   logic              busy_r;

   ds_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (din),
      .q     (ds_s)
   );

   // Frame FSM: next state, bit timing counters and shift register
   always_comb begin
      state_nxt_s     = state_r;
      bitcnt_nxt_s    = bitcnt_r;
      idx_nxt_s       = idx_r;
      shift_nxt_s     = shift_r;
      deliver_s       = 1'b0;
      frame_err_nxt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            bitcnt_nxt_s = BIT_W'(0);
            idx_nxt_s    = IDX_W'(0);
            if ((ds_s == ~LINE_IDLE) && (ds_prev_r == LINE_IDLE)) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (bitcnt_r == BIT_MID) begin
               bitcnt_nxt_s = BIT_W'(0);
               idx_nxt_s    = IDX_W'(0);
               if (ds_s == ~LINE_IDLE) begin
                  state_nxt_s = ST_DATA;
               end else begin
                  state_nxt_s = ST_IDLE;   // glitch, silently ignored
               end
            end else begin
               bitcnt_nxt_s = bitcnt_r + BIT_W'(1);
            end
         end
         ST_DATA: begin
            if (bitcnt_r == BIT_LAST) begin
               bitcnt_nxt_s = BIT_W'(0);
               idx_nxt_s    = idx_r + IDX_W'(1);
               for (int i = 0; i < DATA_W; i++) begin
                  if (idx_r == IDX_W'(i)) begin
                     shift_nxt_s[i] = ds_s;
                  end else begin
                     shift_nxt_s[i] = shift_r[i];
                  end
               end
               if (idx_r == IDX_LAST) begin
                  state_nxt_s = ST_STOP;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end else begin
               bitcnt_nxt_s = bitcnt_r + BIT_W'(1);
            end
         end
         ST_STOP: begin
            if (bitcnt_r == BIT_LAST) begin
               bitcnt_nxt_s = BIT_W'(0);
               if (ds_s == LINE_IDLE) begin
                  deliver_s   = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  frame_err_nxt_s = 1'b1;
                  state_nxt_s     = ST_WAIT_IDLE;
               end
            end else begin
               bitcnt_nxt_s = bitcnt_r + BIT_W'(1);
            end
         end
         ST_WAIT_IDLE: begin
            // A held-low line (break) must not retrigger framing errors
            if (ds_s == LINE_IDLE) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   assign take_s = out_valid_r & out_ready;

   // Holding register: load when empty or draining, otherwise flag overrun
   always_comb begin
      out_data_nxt_s  = out_data_r;
      out_valid_nxt_s = out_valid_r;
      overrun_nxt_s   = 1'b0;
      if (deliver_s) begin
         if (!out_valid_r || take_s) begin
            out_data_nxt_s  = shift_r;
            out_valid_nxt_s = 1'b1;
         end else begin
            overrun_nxt_s = 1'b1;
         end
      end else if (take_s) begin
         out_valid_nxt_s = 1'b0;
      end else begin
         out_valid_nxt_s = out_valid_r;
      end
   end

   // State, counters, data path and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         ds_prev_r   <= LINE_IDLE;
         bitcnt_r    <= BIT_W'(0);
         idx_r       <= IDX_W'(0);
         shift_r     <= DATA_W'(0);
         out_data_r  <= DATA_W'(0);
         out_valid_r <= 1'b0;
         overrun_r   <= 1'b0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         ds_prev_r   <= ds_s;
         bitcnt_r    <= bitcnt_nxt_s;
         idx_r       <= idx_nxt_s;
         shift_r     <= shift_nxt_s;
         out_data_r  <= out_data_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         overrun_r   <= overrun_nxt_s;
         frame_err_r <= frame_err_nxt_s;
         busy_r      <= (state_nxt_s != ST_IDLE);
      end
   end

   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign overrun   = overrun_r;
   assign frame_err = frame_err_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_ds_serial_rx.sv
// Self-checking bench for ds_serial_rx (DATA_W=8, CLKS_PER_BIT=16, SYNC_STAGES=2).
module tb_ds_serial_rx;

   localparam int CPB = 16;

   logic       clk;
   logic       rst_n;
   logic       din;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       frame_err;
   logic       overrun;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // monitor bookkeeping
   int n_xfer, n_ferr, n_ovr, valid_cycles;
   int last_xfer, last_ferr, last_ovr, busy_first, busy_last;
   logic [7:0] sb[$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_xfer;
      int         exp_ferr;
   } vec_t;
   vec_t vecs[6];

   ds_serial_rx #(
      .DATA_W       (8),
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle counter: value k holds from posedge k to posedge k+1
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // output monitor and scoreboard, sampled on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out_valid) valid_cycles = valid_cycles + 1;
            if (busy) begin
               if (busy_first < 0) busy_first = cyc;
               busy_last = cyc;
            end
            if (frame_err) begin
               n_ferr = n_ferr + 1;
               last_ferr = cyc;
            end
            if (overrun) begin
               n_ovr = n_ovr + 1;
               last_ovr = cyc;
            end
            if (out_valid && out_ready) begin
               n_xfer = n_xfer + 1;
               last_xfer = cyc;
               if (sb.size() == 0) begin
                  checks = checks + 1;
                  errors = errors + 1;
                  $display("FAIL sb_unexpected: got transfer of 0x%0h, expected none at cycle %0d",
                           out_data, cyc);
               end else begin
                  check("sb_data", int'(out_data), int'(sb.pop_front()));
               end
            end
         end
      end
   end

   task automatic clear_mon();
      n_xfer = 0; n_ferr = 0; n_ovr = 0; valid_cycles = 0;
      last_xfer = -1; last_ferr = -1; last_ovr = -1;
      busy_first = -1; busy_last = -1;
   endtask

   // hold din at v for one bit time; entered and left at posedge+1
   task automatic hold(input logic v);
      din = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // drive one frame; t0 is the cycle the synchronized line first reads low
   task automatic send_frame(input logic [7:0] d, input logic stop_b, output int t0);
      t0 = cyc + 2;
      hold(1'b0);
      for (int i = 0; i < 8; i++) hold(d[i]);
      hold(stop_b);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int t0, t1, c, r;

      vecs[0] = '{8'hA5, 1'b1, 1, 0};
      vecs[1] = '{8'h00, 1'b1, 1, 0};
      vecs[2] = '{8'hFF, 1'b1, 1, 0};
      vecs[3] = '{8'h80, 1'b1, 1, 0};
      vecs[4] = '{8'h96, 1'b0, 0, 1};
      vecs[5] = '{8'h01, 1'b1, 1, 0};

      clear_mon();
      rst_n = 1'b0;
      din = 1'b1;
      out_ready = 1'b0;
      #12;
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_err", int'(frame_err), 0);
      check("rst_overrun", int'(overrun), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(10);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_valid", int'(out_valid), 0);

      // table-driven frames with the consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         clear_mon();
         if (vecs[i].exp_xfer == 1) sb.push_back(vecs[i].data);
         send_frame(vecs[i].data, vecs[i].stop, t0);
         din = 1'b1;
         idle(8);
         check("vec_xfer", n_xfer, vecs[i].exp_xfer);
         check("vec_ferr", n_ferr, vecs[i].exp_ferr);
         check("vec_ovr", n_ovr, 0);
         check("vec_valid_cycles", valid_cycles, vecs[i].exp_xfer);
         if (vecs[i].exp_xfer == 1) check("vec_xfer_time", last_xfer, t0 + 153);
         else                      check("vec_ferr_time", last_ferr, t0 + 153);
         check("vec_busy_rise", busy_first, t0 + 1);
      end

      // short low glitch is rejected at the start-bit sample
      clear_mon();
      c = cyc;
      din = 1'b0;
      idle(3);
      din = 1'b1;
      idle(30);
      check("glitch_busy_first", busy_first, c + 3);
      check("glitch_busy_last", busy_last, c + 10);
      check("glitch_xfer", n_xfer, 0);
      check("glitch_ferr", n_ferr, 0);
      check("glitch_valid", valid_cycles, 0);

      // bad stop bit followed by a long break
      clear_mon();
      send_frame(8'h3C, 1'b0, t0);
      idle(100);
      r = cyc;
      din = 1'b1;
      idle(10);
      check("break_ferr_count", n_ferr, 1);
      check("break_ferr_time", last_ferr, t0 + 153);
      check("break_valid", valid_cycles, 0);
      check("break_busy_last", busy_last, r + 2);
      check("break_busy_now", int'(busy), 0);

      // overrun: consumer stalled across two frames
      clear_mon();
      out_ready = 1'b0;
      sb.push_back(8'h11);
      send_frame(8'h11, 1'b1, t0);
      send_frame(8'h22, 1'b1, t1);
      idle(4);
      check("ovr_count", n_ovr, 1);
      check("ovr_time", last_ovr, t1 + 153);
      check("ovr_held_data", int'(out_data), 32'h11);
      check("ovr_valid", int'(out_valid), 1);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      idle(2);
      check("ovr_drain_xfer", n_xfer, 1);
      check("ovr_drain_valid", int'(out_valid), 0);

      // back-to-back: read and reload in the same cycle
      clear_mon();
      sb.push_back(8'h01);
      send_frame(8'h01, 1'b1, t0);
      sb.push_back(8'h02);
      fork
         send_frame(8'h02, 1'b1, t1);
         begin
            repeat (154) @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
         end
      join
      check("b2b_stop_time", last_xfer, t1 + 152);
      check("b2b_xfer", n_xfer, 1);
      check("b2b_ovr", n_ovr, 0);
      check("b2b_valid", int'(out_valid), 1);
      check("b2b_data", int'(out_data), 32'h02);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      idle(2);
      check("b2b_drain_xfer", n_xfer, 2);

      // reset in the middle of data bit 4 of a frame
      send_frame(8'h77, 1'b1, t0);
      idle(4);
      hold(1'b0);
      for (int i = 0; i < 4; i++) hold(1'b1);
      din = 1'b0;
      idle(8);
      #2;
      check("mid_busy_pre", int'(busy), 1);
      check("mid_valid_pre", int'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_data", int'(out_data), 0);
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_ferr", int'(frame_err), 0);
      check("mid_rst_ovr", int'(overrun), 0);
      din = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(20);
      clear_mon();
      out_ready = 1'b1;
      sb.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, t0);
      idle(8);
      check("after_rst_xfer", n_xfer, 1);
      check("after_rst_time", last_xfer, t0 + 153);
      check("after_rst_ferr", n_ferr, 0);
      check("after_rst_ovr", n_ovr, 0);

      check("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
